// File: rtl/pulse_event_arb.sv
// rtl/pulse_event_arb.sv - round-robin merge of per-source event pulses into one spaced pulse stream
//
// Purpose:
//   Each source k raises req[k] for one cycle per event. Events are banked in a
//   per-source saturating pending counter, so coincident or bursty events are
//   not lost. A two-state FSM issues one o_pulse per banked event, tagged with
//   the source ID. Consecutive pulses are spaced at least GAP cycles apart so
//   that a shared pulse synchroniser downstream can keep up. Grants rotate
//   round-robin, starting after the last granted source.
//
// Ports:
//   clk          in   1     single clock, all state on posedge
//   reset_l      in   1     synchronous active-low reset
//   req          in   N     one-cycle event pulse per source
//   en           in   1     1 = grants allowed, 0 = hold off (events still counted)
//   clr_overflow in   1     clears all overflow bits (a same-cycle set wins)
//   o_pulse      out  1     one-cycle pulse per granted event
//   o_id         out  IDW   source of the current/last grant, holds between pulses
//   overflow     out  N     sticky, an event was dropped on saturated source k
//   busy         out  1     FSM not idle or any pending count nonzero

module pulse_event_arb #(
    parameter int N    = 4,
    parameter int IDW  = 2,
    parameter int GAP  = 4,
    parameter int CNTW = 4
) (
    input  logic           clk,
    input  logic           reset_l,
    input  logic [N-1:0]   req,
    input  logic           en,
    input  logic           clr_overflow,
    output logic           o_pulse,
    output logic [IDW-1:0] o_id,
    output logic [N-1:0]   overflow,
    output logic           busy
);

    // Gap counter only ever holds values up to GAP-2.
    localparam int GW = $clog2(GAP);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [IDW-1:0]  last_id_q, last_id_d;
    logic            o_pulse_q, o_pulse_d;
    logic [IDW-1:0]  o_id_q, o_id_d;
    logic [N-1:0]    ovf_q, ovf_d;
    logic [CNTW-1:0] cnt_q [N];
    logic [CNTW-1:0] cnt_d [N];

    logic            grant;
    logic [IDW-1:0]  win_id;
    logic            any_pend;
    logic [N-1:0]    set_ovf;

    // Round-robin pick over the registered counts. Scanning from the far end
    // of the rotation back toward last_id+1 lets the closest candidate
    // overwrite the others, so no priority-found flag is needed.
    always_comb begin
        int idx;
        logic [IDW-1:0] idx_w;
        win_id   = last_id_q;
        any_pend = 1'b0;
        for (int i = N; i >= 1; i--) begin
            idx = int'(last_id_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = idx[IDW-1:0];
            if (cnt_q[idx_w] != '0) begin
                win_id   = idx_w;
                any_pend = 1'b1;
            end
        end
    end

    // FSM next-state and grant generation.
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        last_id_d = last_id_q;
        o_pulse_d = 1'b0;
        o_id_d    = o_id_q;
        grant     = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && any_pend) begin
                    grant     = 1'b1;
                    o_pulse_d = 1'b1;
                    o_id_d    = win_id;
                    last_id_d = win_id;
                    // Pulse cycle plus GAP-2 further HOLD cycles plus the
                    // IDLE grant cycle give exactly GAP cycles between pulses.
                    gap_d     = GW'(GAP - 2);
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pending counters and sticky overflow. A request coinciding with a
    // grant to the same source cancels out and never overflows.
    always_comb begin
        logic g;
        set_ovf = '0;
        for (int k = 0; k < N; k++) begin
            g        = grant && (win_id == IDW'(k));
            cnt_d[k] = cnt_q[k];
            if (req[k] && !g) begin
                if (cnt_q[k] == '1) begin
                    set_ovf[k] = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end else if (g && !req[k]) begin
                cnt_d[k] = cnt_q[k] - 1'b1;
            end
        end
        ovf_d = (clr_overflow ? '0 : ovf_q) | set_ovf;
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q   <= IDLE;
            gap_q     <= '0;
            last_id_q <= IDW'(N - 1);
            o_pulse_q <= 1'b0;
            o_id_q    <= '0;
            ovf_q     <= '0;
            for (int k = 0; k < N; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            last_id_q <= last_id_d;
            o_pulse_q <= o_pulse_d;
            o_id_q    <= o_id_d;
            ovf_q     <= ovf_d;
            for (int k = 0; k < N; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign o_pulse  = o_pulse_q;
    assign o_id     = o_id_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != IDLE) || any_pend;

endmodule

// File: tb/tb_pulse_event_arb.sv
// tb/tb_pulse_event_arb.sv - scoreboard bench for pulse_event_arb with directed and random stimulus
module tb_pulse_event_arb;

    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int GAP  = 4;
    localparam int CNTW = 4;
    localparam int MAXC = (1 << CNTW) - 1;

    logic           clk = 1'b0;
    logic           reset_l;
    logic [N-1:0]   req;
    logic           en;
    logic           clr_overflow;
    logic           o_pulse;
    logic [IDW-1:0] o_id;
    logic [N-1:0]   overflow;
    logic           busy;

    pulse_event_arb #(.N(N), .IDW(IDW), .GAP(GAP), .CNTW(CNTW)) dut (
        .clk          (clk),
        .reset_l      (reset_l),
        .req          (req),
        .en           (en),
        .clr_overflow (clr_overflow),
        .o_pulse      (o_pulse),
        .o_id         (o_id),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int id;
    } exp_t;

    exp_t q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int npulse = 0;

    // Reference model state: backlog per source, cycles before another grant
    // may be issued, rotation pointer, last id shown, sticky drop flags.
    int pend [N];
    int cool;
    int last;
    int oid;
    int ovf;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock edge of the reference behaviour, using the inputs just applied.
    task automatic model_step();
        int granted;
        int idx;
        int setm;
        cyc++;
        if (!reset_l) begin
            for (int k = 0; k < N; k++) pend[k] = 0;
            cool = 0;
            last = N - 1;
            oid  = 0;
            ovf  = 0;
            q.delete();
            return;
        end
        granted = -1;
        if (cool > 0) begin
            cool--;
        end else if (en) begin
            for (int j = 1; j <= N; j++) begin
                idx = (last + j) % N;
                if (granted < 0 && pend[idx] > 0) granted = idx;
            end
            if (granted >= 0) begin
                last = granted;
                oid  = granted;
                cool = GAP - 1;
                q.push_back('{cyc, granted});
            end
        end
        setm = 0;
        for (int k = 0; k < N; k++) begin
            if (req[k] && granted != k) begin
                if (pend[k] == MAXC) setm |= (1 << k);
                else pend[k]++;
            end else if (!req[k] && granted == k) begin
                pend[k]--;
            end
        end
        ovf = (clr_overflow ? 0 : ovf) | setm;
    endtask

    task automatic step(input logic [N-1:0] r, input logic e, input logic c, input logic rl);
        req          = r;
        en           = e;
        clr_overflow = c;
        reset_l      = rl;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drain(input string nm);
        int i;
        for (i = 0; i < 300; i++) begin
            step('0, 1'b1, 1'b0, 1'b1);
            if (!busy) break;
        end
        n_cmp++;
        if (i >= 300) begin
            n_err++;
            $display("FAIL %s_drain: busy still 1 after %0d cycles, required 0", nm, i);
        end
    endtask

    // Monitor: every cycle, compare outputs against the scoreboard/model.
    initial begin
        bit exp_p;
        int mbusy;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                exp_p = (q.size() > 0) && (q[0].cyc == cyc);
                check("o_pulse", int'(o_pulse), int'(exp_p));
                if (exp_p) void'(q.pop_front());
                check("o_id", int'(o_id), oid);
                check("overflow", int'(overflow), ovf);
                mbusy = (cool > 0) ? 1 : 0;
                for (int k = 0; k < N; k++) if (pend[k] > 0) mbusy = 1;
                check("busy", int'(busy), mbusy);
                if (o_pulse) npulse++;
            end
        end
    end

    initial begin
        int base;
        logic [N-1:0] r;
        req = '0; en = 1'b1; clr_overflow = 1'b0; reset_l = 1'b0;

        step('0, 1'b1, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0, 1'b0);
        check("rst_pulse", int'(o_pulse), 0);
        check("rst_id", int'(o_id), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_busy", int'(busy), 0);
        step('0, 1'b1, 1'b0, 1'b1);

        // Single event on source 2.
        base = npulse;
        step(4'b0100, 1'b1, 1'b0, 1'b1);
        drain("single");
        check("single_count", npulse - base, 1);

        // All four sources at once.
        base = npulse;
        step(4'b1111, 1'b1, 1'b0, 1'b1);
        drain("coincident");
        check("coincident_count", npulse - base, 4);

        // Source 1 every cycle with single events on 0 and 3.
        base = npulse;
        step(4'b1011, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) step(4'b0010, 1'b1, 1'b0, 1'b1);
        drain("fair");
        check("fair_count", npulse - base, 14);

        // Saturation of source 0 while grants are held off.
        for (int i = 0; i < 17; i++) begin
            step(4'b0001, 1'b0, 1'b0, 1'b1);
            if (i == 15) check("sat_ovf16", int'(overflow), 1);
        end
        step('0, 1'b0, 1'b0, 1'b1);
        check("sat_ovf", int'(overflow), 1);
        base = npulse;
        drain("sat");
        check("sat_count", npulse - base, 15);
        check("sat_ovf_held", int'(overflow), 1);
        step('0, 1'b1, 1'b1, 1'b1);
        check("sat_clr", int'(overflow), 0);

        // Request on source 2 in the same cycle as its grant.
        base = npulse;
        step(4'b0100, 1'b1, 1'b0, 1'b1);
        step(4'b0100, 1'b1, 1'b0, 1'b1);
        drain("simul");
        check("simul_count", npulse - base, 2);

        // Reset mid-HOLD with counts 3,0,2,0.
        step(4'b0101, 1'b0, 1'b0, 1'b1);
        step(4'b0101, 1'b0, 1'b0, 1'b1);
        step(4'b0001, 1'b0, 1'b0, 1'b1);
        step('0, 1'b1, 1'b0, 1'b1);
        step('0, 1'b1, 1'b0, 1'b0);
        check("midrst_busy", int'(busy), 0);
        base = npulse;
        for (int i = 0; i < 10; i++) step('0, 1'b1, 1'b0, 1'b1);
        check("midrst_count", npulse - base, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++) r[k] = ($urandom_range(5) == 0);
            step(r, $urandom_range(9) != 0, $urandom_range(31) == 0,
                 $urandom_range(499) != 0);
        end
        drain("random");
        check("queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
